// File: rtl/fmat_pkg.sv
// fmat_pkg: shared widths and the pending-write queue entry for the writeback stage.
package fmat_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 2;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
        logic                  dv;
    } wb_entry_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: execute, memory, regfile write/read and forwarding signals of the writeback stage.
interface wb_stage_if;
    import fmat_pkg::*;
    logic                  ex_valid_i, ex_ready_o, ex_wr_i, ex_is_load_i;
    logic [ADDR_WIDTH-1:0] ex_rd_i;
    logic [DATA_WIDTH-1:0] ex_data_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  rf_wen_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic [ADDR_WIDTH-1:0] rd1_addr_i, rd2_addr_i;
    logic [DATA_WIDTH-1:0] rf_rd1_i, rf_rd2_i, fwd1_o, fwd2_o;
    logic                  hazard1_o, hazard2_o, err_o;

    modport slave (
        input  ex_valid_i, ex_wr_i, ex_is_load_i, ex_rd_i, ex_data_i,
               mem_rvalid_i, mem_rdata_i, rd1_addr_i, rd2_addr_i, rf_rd1_i, rf_rd2_i,
        output ex_ready_o, rf_wen_o, rf_waddr_o, rf_wdata_o,
               fwd1_o, fwd2_o, hazard1_o, hazard2_o, err_o
    );
    modport master (
        output ex_valid_i, ex_wr_i, ex_is_load_i, ex_rd_i, ex_data_i,
               mem_rvalid_i, mem_rdata_i, rd1_addr_i, rd2_addr_i, rf_rd1_i, rf_rd2_i,
        input  ex_ready_o, rf_wen_o, rf_waddr_o, rf_wdata_o,
               fwd1_o, fwd2_o, hazard1_o, hazard2_o, err_o
    );
endinterface

// File: rtl/wb_bypass_mux.sv
// wb_bypass_mux: one read port's bypass; youngest queue match wins, then the in-flight write, then the regfile.
module wb_bypass_mux
    import fmat_pkg::*;
(
    input  wb_entry_t             e0,
    input  wb_entry_t             e1,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] fwd,
    output logic                  hazard
);
    logic      m0, m1;
    wb_entry_t hit;

    assign m0     = e0.valid && e0.rd == addr;
    assign m1     = e1.valid && e1.rd == addr;
    assign hit    = m1 ? e1 : e0;
    assign hazard = (m0 || m1) && !hit.dv;
    assign fwd    = (m0 || m1) ? (hit.dv ? hit.data : rf_rd) :
                    (wen && waddr == addr) ? wdata : rf_rd;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: 2-entry in-order writeback queue feeding the regfile write port, with load fill and operand bypass.
module wb_stage
    import fmat_pkg::*;
(
    input logic       clk,
    input logic       rst_i,
    wb_stage_if.slave bus
);
    wb_entry_t             q0, q1, f0, f1, p0, p1, n0, n1, in_e;
    logic                  pop, push, fill0, fill1;
    logic                  wen_q, err_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign bus.ex_ready_o = !rst_i && !(q0.valid && q1.valid);
    assign bus.rf_wen_o   = wen_q;
    assign bus.rf_waddr_o = waddr_q;
    assign bus.rf_wdata_o = wdata_q;
    assign bus.err_o      = err_q;

    // q0 is always the oldest entry; fill applies first, then pop shifts, then push lands in the first free slot
    always_comb begin
        pop   = q0.valid && q0.dv;
        push  = bus.ex_valid_i && bus.ex_ready_o && bus.ex_wr_i;
        fill0 = bus.mem_rvalid_i && q0.valid && !q0.dv;
        fill1 = bus.mem_rvalid_i && !fill0 && q1.valid && !q1.dv;
        f0    = fill0 ? '{1'b1, q0.rd, bus.mem_rdata_i, 1'b1} : q0;
        f1    = fill1 ? '{1'b1, q1.rd, bus.mem_rdata_i, 1'b1} : q1;
        in_e  = '{1'b1, bus.ex_rd_i, bus.ex_is_load_i ? '0 : bus.ex_data_i, !bus.ex_is_load_i};
        p0    = pop ? f1 : f0;
        p1    = pop ? '0 : f1;
        n0    = (push && !p0.valid) ? in_e : p0;
        n1    = (push && p0.valid) ? in_e : p1;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            q0      <= '0;
            q1      <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            q0    <= n0;
            q1    <= n1;
            wen_q <= pop;
            if (pop) begin
                waddr_q <= q0.rd;
                wdata_q <= q0.data;
            end
            if (bus.mem_rvalid_i && !fill0 && !fill1) err_q <= 1'b1;
        end
    end

    wb_bypass_mux u_byp1 (
        .e0(q0), .e1(q1), .wen(wen_q), .waddr(waddr_q), .wdata(wdata_q),
        .addr(bus.rd1_addr_i), .rf_rd(bus.rf_rd1_i), .fwd(bus.fwd1_o), .hazard(bus.hazard1_o)
    );
    wb_bypass_mux u_byp2 (
        .e0(q0), .e1(q1), .wen(wen_q), .waddr(waddr_q), .wdata(wdata_q),
        .addr(bus.rd2_addr_i), .rf_rd(bus.rf_rd2_i), .fwd(bus.fwd2_o), .hazard(bus.hazard2_o)
    );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench; the model tracks each register's newest value and the pending writes in program order.
module tb_wb_stage;
    import fmat_pkg::*;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if bus();
    wb_stage dut (.clk(clk), .rst_i(rst_i), .bus(bus));

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        bit         known;
        int         seq;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tb_rf[8];
    logic [7:0] arch[8];
    bit         pend[8];
    int         lastw[8];
    int         seq = 0;
    bit         exp_err = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // bench acts as the register file
    assign bus.rf_rd1_i = tb_rf[bus.rd1_addr_i];
    assign bus.rf_rd2_i = tb_rf[bus.rd2_addr_i];
    always @(posedge clk) if (bus.rf_wen_o === 1'b1) tb_rf[bus.rf_waddr_o] <= bus.rf_wdata_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // monitor: every regfile write must be the oldest outstanding write, with its final data
    always @(negedge clk) begin
        if (bus.rf_wen_o === 1'b1) begin
            chk("wr_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("wr_known", x.known, 1);
                chk("wr_addr", bus.rf_waddr_o, x.rd);
                chk("wr_data", bus.rf_wdata_o, x.data);
            end
        end
    end

    function automatic bit has_unknown();
        foreach (sb[i]) if (!sb[i].known) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit v, input bit w, input bit l, input logic [2:0] rd, input logic [7:0] d,
                        input bit mrv, input logic [7:0] md, input logic [2:0] a1, input logic [2:0] a2);
        bit rdy, acc, hit;
        @(negedge clk);
        bus.ex_valid_i = v; bus.ex_wr_i = w; bus.ex_is_load_i = l;
        bus.ex_rd_i = rd; bus.ex_data_i = d;
        bus.mem_rvalid_i = mrv; bus.mem_rdata_i = md;
        bus.rd1_addr_i = a1; bus.rd2_addr_i = a2;
        #1;
        rdy = sb.size() < 2;
        chk("ready", bus.ex_ready_o, rdy);
        chk("fwd1", bus.fwd1_o, pend[a1] ? tb_rf[a1] : arch[a1]);
        chk("haz1", bus.hazard1_o, pend[a1]);
        chk("fwd2", bus.fwd2_o, pend[a2] ? tb_rf[a2] : arch[a2]);
        chk("haz2", bus.hazard2_o, pend[a2]);
        chk("err", bus.err_o, exp_err);
        acc = v && rdy;
        @(posedge clk);
        if (mrv) begin
            hit = 1'b0;
            foreach (sb[i]) begin
                if (!hit && !sb[i].known) begin
                    hit = 1'b1;
                    sb[i].data = md;
                    sb[i].known = 1'b1;
                    if (lastw[sb[i].rd] == sb[i].seq) begin
                        arch[sb[i].rd] = md;
                        pend[sb[i].rd] = 1'b0;
                    end
                end
            end
            if (!hit) exp_err = 1'b1;
        end
        if (acc && w) begin
            seq++;
            lastw[rd] = seq;
            sb.push_back('{rd, l ? 8'h00 : d, !l, seq});
            if (l) pend[rd] = 1'b1;
            else begin
                arch[rd] = d;
                pend[rd] = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
        step(0, 0, 0, 3'd0, 8'h00, 0, 8'h00, a1, a2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        bus.ex_valid_i = 0; bus.mem_rvalid_i = 0;
        #1 chk("ready_in_rst", bus.ex_ready_o, 0);
        @(posedge clk);
        sb.delete();
        exp_err = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) begin
            arch[r] = tb_rf[r];
            pend[r] = 1'b0;
        end
        @(negedge clk);
        chk("rst_wen", bus.rf_wen_o, 0);
        chk("rst_waddr", bus.rf_waddr_o, 0);
        chk("rst_wdata", bus.rf_wdata_o, 0);
        chk("rst_err", bus.err_o, 0);
        rst_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 30) begin
            step(0, 0, 0, 3'd0, 8'h00, has_unknown(), 8'($urandom), 3'($urandom), 3'($urandom));
            n++;
        end
        chk("drain_left", sb.size(), 0);
        idle(0, 1);
        idle(2, 3);
    endtask

    initial begin
        bus.ex_valid_i = 0; bus.ex_wr_i = 0; bus.ex_is_load_i = 0; bus.ex_rd_i = 0; bus.ex_data_i = 0;
        bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.rd1_addr_i = 0; bus.rd2_addr_i = 0;
        for (int r = 0; r < 8; r++) begin
            tb_rf[r] = 8'($urandom);
            arch[r] = tb_rf[r];
            pend[r] = 1'b0;
            lastw[r] = 0;
        end
        do_reset();

        // single ALU write: visible on the write port exactly one cycle after the cycle it sat queued
        step(1, 1, 0, 3'd3, 8'hCC, 0, 8'h00, 3'd3, 3'd0);
        #2 chk("t1_wen_k", bus.rf_wen_o, 0);
        idle(3'd3, 3'd3);
        #2 chk("t1_wen_k1", bus.rf_wen_o, 1);
        chk("t1_waddr", bus.rf_waddr_o, 3);
        chk("t1_wdata", bus.rf_wdata_o, 8'hCC);
        idle(3'd3, 3'd0);
        #2 chk("t1_wen_k2", bus.rf_wen_o, 0);

        // load at head blocks a younger ALU write until the fill arrives
        step(1, 1, 1, 3'd5, 8'h00, 0, 8'h00, 3'd5, 3'd2);
        step(1, 1, 0, 3'd2, 8'h55, 0, 8'h00, 3'd5, 3'd2);
        idle(3'd5, 3'd2);
        idle(3'd5, 3'd2);
        step(0, 0, 0, 3'd0, 8'h00, 1, 8'hA7, 3'd5, 3'd2);
        repeat (3) idle(3'd5, 3'd2);

        // back-to-back writes to the same register
        step(1, 1, 0, 3'd4, 8'h11, 0, 8'h00, 3'd4, 3'd4);
        step(1, 1, 0, 3'd4, 8'h22, 0, 8'h00, 3'd4, 3'd4);
        repeat (3) idle(3'd4, 3'd4);
        chk("t3_rf4", tb_rf[4], 8'h22);

        // non-writing result refused while full, then accepted without allocation
        step(1, 1, 1, 3'd6, 8'h00, 0, 8'h00, 3'd6, 3'd1);
        step(1, 1, 0, 3'd1, 8'h01, 0, 8'h00, 3'd6, 3'd1);
        step(1, 0, 0, 3'd7, 8'h99, 0, 8'h00, 3'd7, 3'd6);
        step(0, 0, 0, 3'd0, 8'h00, 1, 8'h5A, 3'd6, 3'd1);
        idle(3'd6, 3'd1);
        step(1, 0, 0, 3'd7, 8'h99, 0, 8'h00, 3'd7, 3'd6);
        repeat (3) idle(3'd7, 3'd1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                 3'($urandom), 8'($urandom),
                 has_unknown() && $urandom_range(0, 9) < 4, 8'($urandom),
                 3'($urandom), 3'($urandom));
        end
        drain();
        for (int r = 0; r < 8; r++) chk("rf_final", tb_rf[r], arch[r]);

        // stray load data with nothing pending: sticky error, no write
        step(0, 0, 0, 3'd0, 8'h00, 1, 8'h5A, 3'd0, 3'd1);
        repeat (3) idle(3'd2, 3'd3);

        // reset with two entries pending discards them
        step(1, 1, 1, 3'd7, 8'h00, 0, 8'h00, 3'd7, 3'd0);
        step(1, 1, 0, 3'd0, 8'h3C, 0, 8'h00, 3'd7, 3'd0);
        do_reset();
        idle(3'd7, 3'd0);
        #2 chk("rst_no_stale_wen", bus.rf_wen_o, 0);
        idle(3'd0, 3'd7);
        step(1, 1, 0, 3'd0, 8'h3D, 0, 8'h00, 3'd0, 3'd7);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
